// File: rtl/traffic_phase_sched.sv
// Timed phase sequencer for the two-road traffic-light controller: drives the lamp
// decoder's phase code, a per-phase seconds countdown and pedestrian green truncation.
module traffic_phase_sched #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned T_GREEN1 = 30,
    parameter int unsigned T_GREEN2 = 20,
    parameter int unsigned T_YELLOW = 5,
    parameter int unsigned T_MIN    = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    input  logic       PED_REQ,
    output logic [1:0] EN_out,
    output logic [7:0] CNT_out,
    output logic       PHASE_START,
    output logic       PED_PEND
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] PH_GREEN1  = 2'b00;
    localparam logic [1:0] PH_YELLOW1 = 2'b01;
    localparam logic [1:0] PH_GREEN2  = 2'b10;
    localparam logic [1:0] PH_YELLOW2 = 2'b11;

    localparam logic [7:0] DUR_GREEN1 = 8'(T_GREEN1);
    localparam logic [7:0] DUR_GREEN2 = 8'(T_GREEN2);
    localparam logic [7:0] DUR_YELLOW = 8'(T_YELLOW);
    localparam logic [7:0] DUR_MIN    = 8'(T_MIN);

    logic [PW-1:0] presc;
    logic          tick;
    logic          is_green;
    logic          truncate;
    logic          phase_end;
    logic [1:0]    next_phase;
    logic [7:0]    next_dur;

    assign tick       = SW1 && (presc == PRESC_MAX);
    assign is_green   = ~EN_out[0];
    // A truncation can only fire while CNT_out > T_MIN >= 1, so it never collides with a phase end.
    assign truncate   = PED_PEND && SW1 && is_green && (CNT_out > DUR_MIN);
    assign phase_end  = tick && (CNT_out == 8'd1) && !truncate;
    assign next_phase = EN_out + 2'd1;

    always_comb begin
        next_dur = DUR_GREEN1;
        case (next_phase)
            PH_GREEN1:  next_dur = DUR_GREEN1;
            PH_YELLOW1: next_dur = DUR_YELLOW;
            PH_GREEN2:  next_dur = DUR_GREEN2;
            PH_YELLOW2: next_dur = DUR_YELLOW;
            default:    next_dur = DUR_GREEN1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (SW1) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EN_out      <= PH_GREEN1;
            CNT_out     <= DUR_GREEN1;
            PHASE_START <= 1'b0;
        end else begin
            PHASE_START <= phase_end;
            if (truncate) begin
                CNT_out <= DUR_MIN;
            end else if (phase_end) begin
                EN_out  <= next_phase;
                CNT_out <= next_dur;
            end else if (tick) begin
                CNT_out <= CNT_out - 8'd1;
            end
        end
    end

    // A new request always wins over a same-cycle clear so it is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PED_PEND <= 1'b0;
        end else if (PED_REQ) begin
            PED_PEND <= 1'b1;
        end else if (truncate || (phase_end && is_green)) begin
            PED_PEND <= 1'b0;
        end
    end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Timed phase sequencer for the two-road traffic-light controller. Generates the 2-bit phase code consumed by the lamp decoder: 00 road-1 green, 01 road-1 yellow, 10 road-2 green, 11 road-2 yellow. Also produces a per-phase seconds countdown for the display path, and handles pedestrian requests by shortening the current green. Sits between the board clock and the lamp decoder, and shares the decoder's SW1 run switch.

## Interface
- TICK_DIV, 100000000: CLK cycles per one-second tick; legal 2..2^27.
- T_GREEN1, 30: road-1 green duration in seconds; legal 1..255.
- T_GREEN2, 20: road-2 green duration in seconds; legal 1..255.
- T_YELLOW, 5: yellow duration in seconds, both roads; legal 1..255.
- T_MIN, 5: remaining green after a pedestrian truncation; legal 1..255.
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- SW1  input  1  run enable; 0 pauses the sequencer.
- PED_REQ  input  1  pedestrian request, level or pulse, synchronous to CLK.
- EN_out  output  2  phase code to the lamp decoder.
- CNT_out  output  8  seconds remaining in the current phase, binary.
- PHASE_START  output  1  one-cycle pulse on the cycle EN_out changes.
- PED_PEND  output  1  pedestrian request latched and not yet served.

## Operation
- State: phase register (EN_out), 8-bit seconds counter (CNT_out), prescaler (ceil(log2 TICK_DIV) bits), ped_pend flag.
- Reset values: EN_out=00, CNT_out=T_GREEN1, prescaler=0, PHASE_START=0, PED_PEND=0.
- Phase order is fixed: 00→01→10→11→00. Durations are T_GREEN1, T_YELLOW, T_GREEN2, T_YELLOW respectively.
- Prescaler counts 0..TICK_DIV-1 while SW1=1. tick is asserted on the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0 on that cycle.
- On tick, if CNT_out>1: CNT_out decrements by 1.
- On tick, if CNT_out==1: EN_out advances to the next phase, CNT_out loads that phase's duration, and PHASE_START=1 on the following cycle.
- CNT_out never shows 0 and is always in 1..255.
- SW1=0: prescaler, CNT_out, EN_out and ped_pend all hold. PED_REQ is still latched into ped_pend. No ticks occur. On resume, counting continues from the held prescaler value.
- ped_pend is set by PED_REQ=1 on any cycle.
- Truncation: when ped_pend=1, SW1=1, EN_out is 00 or 10, and CNT_out>T_MIN, then CNT_out loads T_MIN and ped_pend clears.
  - Truncation has priority over tick decrement in the same cycle. The prescaler still wraps on that cycle.
- ped_pend also clears when a green ends and the sequencer enters 01 or 11. A request already inside the last T_MIN seconds of a green is treated as served.
- A request raised during yellow (01/11) stays pending and is applied in the next green once its CNT_out>T_MIN.
- PED_REQ on the same cycle a clear event happens: the set wins, so ped_pend=1 afterwards.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Phase duration is exactly T×TICK_DIV CLK cycles while SW1 stays high.
  - Exception: the first tick after reset occurs TICK_DIV cycles after RST deasserts.
- EN_out and CNT_out update on the same edge. PHASE_START is high for exactly one cycle, coincident with the new EN_out value.
- PED_REQ→ped_pend latency is 1 cycle. ped_pend→truncated CNT_out latency is 1 further cycle.
- RST asserted mid-phase forces the reset values immediately (asynchronous). After RST deasserts, the sequencer restarts at phase 00 with a full T_GREEN1.
- Full cycle length: (T_GREEN1+T_GREEN2+2·T_YELLOW)·TICK_DIV clocks.

## Test plan
Bench parameters: TICK_DIV=4, T_GREEN1=5, T_GREEN2=3, T_YELLOW=2, T_MIN=2, SW1=1 unless stated.
- Reset then free-run 48 clocks → EN_out sequence 00(20 clk), 01(8), 10(12), 11(8), back to 00. CNT_out counts 5..1, 2..1, 3..1, 2..1. PHASE_START pulses exactly 4 times.
- RST pulse in the middle of phase 10 → EN_out=00 and CNT_out=5 asynchronously. The next tick arrives 4 clocks after release.
- SW1=0 for 10 clocks during phase 01, CNT_out=2 → all outputs frozen. On SW1=1, phase 01 total on-time is 8 enabled clocks.
- 1-cycle PED_REQ at CNT_out=5 in phase 00 → PED_PEND=1 for 1 cycle, then CNT_out=2 and PED_PEND=0. Yellow follows 8 clocks later.
- PED_REQ at CNT_out=2 in phase 00 → no truncation. PED_PEND clears on entry to 01.
- PED_REQ during phase 11 → PED_PEND held through yellow. On entry to 00, CNT_out=5, then truncated to 2 one cycle later.
